arr2_serializer: RTL
====================

Name: arr2_serializer

Overview:
- Drains a captured two-dimensional array of WIDTH-bit elements, one element per cycle, over a valid/ready stream; it is the reader end of the array-register path.
- Sits after a 2-D array pipeline register, e.g. a per-sample result array. It feeds a narrow downstream consumer such as a sample/zbuffer writer.
- Holds one whole array, walks it in row-major order and tags each element with its indices and an end-of-array flag.

Parameters:
- WIDTH, 64, bit width of one element
- ARRAY_SIZE1, 4, first (row) dimension, >=1
- ARRAY_SIZE2, 4, second (column) dimension, >=1

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset; 0 = reset asserted
- in  input  WIDTH x [ARRAY_SIZE1][ARRAY_SIZE2]  unpacked array to capture
- in_valid  input  1  in holds a valid array
- in_ready  output  1  block will capture in this cycle if in_valid
- out  output  WIDTH  current element
- out_idx1  output  I1W = max(1,$clog2(ARRAY_SIZE1))  row index of out
- out_idx2  output  I2W = max(1,$clog2(ARRAY_SIZE2))  column index of out
- out_last  output  1  out is element [ARRAY_SIZE1-1][ARRAY_SIZE2-1]
- out_valid  output  1  out/idx/last are valid
- out_ready  input  1  consumer accepts this cycle

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on port reset. All state clears immediately on reset falling, independent of clk.
- Reset values: state=IDLE, out_valid=0, in_ready=1, out_last=0, idx counters=0, capture buffer all zeros, so out=0.
- State machine:
  - IDLE: in_ready=1, out_valid=0. If in_valid, capture the full array into the buffer, set idx=(0,0) and go to DRAIN.
  - DRAIN: out_valid=1; out = buf[idx1][idx2].
    - Output handshake: out_valid & out_ready.
    - On handshake with idx2 < ARRAY_SIZE2-1: idx2++.
    - On handshake with idx2 = ARRAY_SIZE2-1 (and not last): idx2=0, idx1++.
    - On handshake at the last element: go to IDLE, unless a new array is captured in the same cycle (next bullet).
- in_ready is combinational: in_ready = (state==IDLE) | (state==DRAIN & out_last & out_ready). No combinational path from in_valid to out.
- Back-to-back arrays: if in_valid and in_ready while in DRAIN at the last handshake, capture the new array, reset idx to (0,0) and stay in DRAIN. There are no bubble cycles between arrays.
- Latency: array accepted at edge N; element [0][0] presented with out_valid=1 from edge N until its handshake. One array costs exactly ARRAY_SIZE1*ARRAY_SIZE2 handshake cycles when out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, out, out_idx1, out_idx2 and out_last hold stable. The buffer is never overwritten outside a capture.
- out_last = (state==DRAIN) & (idx1==ARRAY_SIZE1-1) & (idx2==ARRAY_SIZE2-1).
- Degenerate sizes:
  - 1x1: every array yields one element with out_last=1.
  - ARRAY_SIZE2=1: idx2 stays 0 and idx1 increments on every handshake.
- in_valid in DRAIN with no last handshake: ignored (in_ready=0). The upstream holds in.
- Reset mid-drain: the remaining elements are discarded, out_valid drops asynchronously and the block restarts in IDLE after reset deasserts.
- Index counters never exceed their size-1 bound. Unused counter encodings are unreachable.

Decomposition:
- Shared package (rast_stream_pkg):
  - state enum {IDLE, DRAIN}
  - localparam helper for index width, max(1,$clog2(n))
- One natural sub-module: arr2_idx_counter. It is a 2-D row-major index counter with inc, clear, idx1, idx2 and last outputs, parameterized by both sizes. It is reused by any future array-walking block.
- Capture buffer: a plain enable-loaded register array in the top level, loaded on capture.

Test Plan (WIDTH=8, ARRAY_SIZE1=2, ARRAY_SIZE2=3 unless noted; element value = 0x10*i+j):
- Reset with reset=0 mid-stream -> out_valid=0, in_ready=1, out=0 immediately, before any clk edge.
- Single array, out_ready=1 -> on 6 consecutive cycles out=00,01,02,10,11,12, with idx=(0,0)..(1,2). out_last=1 only with out=0x12, then out_valid=0.
- out_ready toggled 1,0,0,1 -> out holds 0x01, idx (0,1), for both stalled cycles. The sequence is unchanged and in_ready stays 0 until the last handshake.
- Two arrays back-to-back (second array = first + 0x80) with in_valid held high -> the second array's 0x80 appears the cycle after 0x12. There are 12 consecutive valid cycles with no bubble.
- reset asserted after the 3rd handshake -> out_valid drops at once. After release, a new array starts again at idx (0,0).
- ARRAY_SIZE1=ARRAY_SIZE2=1, in=0xA5 -> one cycle with out=0xA5, out_last=1, idx (0,0). in_ready=1 in that same cycle when out_ready=1.

Source files
------------

// File: rtl/rast_stream_pkg.sv
// rtl/rast_stream_pkg.sv - shared types and helpers for array stream blocks
//   state_e   : serializer FSM states {IDLE, DRAIN}
//   idx_width : index counter width, max(1, $clog2(n))
package rast_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arr2_idx_counter.sv
// rtl/arr2_idx_counter.sv - 2-D row-major index counter
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   inc_i    : advance one element (row-major, wraps to (0,0) after the last)
//   clear_i  : force (0,0); wins over inc_i
//   idx1_o   : row index
//   idx2_o   : column index
//   last_o   : indices point at [SIZE1-1][SIZE2-1]
module arr2_idx_counter
    import rast_stream_pkg::*;
#(
    parameter int SIZE1 = 4,
    parameter int SIZE2 = 4,
    parameter int I1W   = idx_width(SIZE1),
    parameter int I2W   = idx_width(SIZE2)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           inc_i,
    input  logic           clear_i,
    output logic [I1W-1:0] idx1_o,
    output logic [I2W-1:0] idx2_o,
    output logic           last_o
);

    localparam logic [I1W-1:0] IDX1_MAX = I1W'(SIZE1 - 1);
    localparam logic [I2W-1:0] IDX2_MAX = I2W'(SIZE2 - 1);

    logic [I1W-1:0] idx1_q, idx1_d;
    logic [I2W-1:0] idx2_q, idx2_d;

    always_comb begin
        idx1_d = idx1_q;
        idx2_d = idx2_q;
        if (clear_i) begin
            idx1_d = '0;
            idx2_d = '0;
        end else if (inc_i) begin
            if (idx2_q == IDX2_MAX) begin
                idx2_d = '0;
                // Wrapping past the last element keeps counters inside their bounds.
                idx1_d = (idx1_q == IDX1_MAX) ? '0 : idx1_q + I1W'(1);
            end else begin
                idx2_d = idx2_q + I2W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx1_q <= '0;
            idx2_q <= '0;
        end else begin
            idx1_q <= idx1_d;
            idx2_q <= idx2_d;
        end
    end

    assign idx1_o = idx1_q;
    assign idx2_o = idx2_q;
    assign last_o = (idx1_q == IDX1_MAX) && (idx2_q == IDX2_MAX);

endmodule

// File: rtl/arr2_serializer.sv
// rtl/arr2_serializer.sv - captures a 2-D array and streams it out row-major
//   clk       : clock
//   reset     : asynchronous active-low reset
//   in        : array to capture, [ARRAY_SIZE1][ARRAY_SIZE2] x WIDTH
//   in_valid  : in holds a valid array
//   in_ready  : array is captured this cycle if in_valid
//   out       : current element
//   out_idx1  : row index of out
//   out_idx2  : column index of out
//   out_last  : out is the final element of the array
//   out_valid : out/idx/last are valid
//   out_ready : consumer accepts this cycle
module arr2_serializer
    import rast_stream_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int ARRAY_SIZE1 = 4,
    parameter int ARRAY_SIZE2 = 4,
    parameter int I1W         = idx_width(ARRAY_SIZE1),
    parameter int I2W         = idx_width(ARRAY_SIZE2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in [ARRAY_SIZE1][ARRAY_SIZE2],
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [I1W-1:0]   out_idx1,
    output logic [I2W-1:0]   out_idx2,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cap_q [ARRAY_SIZE1][ARRAY_SIZE2];
    logic             handshake;
    logic             capture;
    logic             cnt_last;

    arr2_idx_counter #(
        .SIZE1 (ARRAY_SIZE1),
        .SIZE2 (ARRAY_SIZE2),
        .I1W   (I1W),
        .I2W   (I2W)
    ) u_idx (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (handshake),
        .clear_i (capture),
        .idx1_o  (out_idx1),
        .idx2_o  (out_idx2),
        .last_o  (cnt_last)
    );

    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && cnt_last;
    assign handshake = out_valid && out_ready;
    // Ready again in the cycle the final element is taken, so arrays chain without a bubble.
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
    assign capture   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = DRAIN;
            DRAIN:   if (handshake && out_last) state_d = capture ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q <= '{default: '0};
        end else if (capture) begin
            cap_q <= in;
        end
    end

    // Compare-based select keeps the mux free of index-width corner cases at size 1.
    always_comb begin
        out = '0;
        for (int i = 0; i < ARRAY_SIZE1; i++) begin
            for (int j = 0; j < ARRAY_SIZE2; j++) begin
                if (out_idx1 == I1W'(i) && out_idx2 == I2W'(j)) begin
                    out = cap_q[i][j];
                end
            end
        end
    end

endmodule
